// File: rtl/otter_io_pkg.sv
// -----------------------------------------------------------------------------
// otter_io_pkg
//   Shared constants and types for the OTTER board-I/O helpers (button
//   debouncer on the input side, pulse stretcher on the output side).
//
//   Contents:
//     stretch_state_e   - pulse stretcher FSM states (ST_idle/ST_high/ST_low)
//     DEF_HIGH_CLKS     - default stretched-pulse high time, clocks
//     DEF_LOW_CLKS      - default guard low time after each pulse, clocks
//     DEF_PEND_W        - default pending-event counter width
//     CNT_W             - width of the stretcher phase counter
//     DB_STABLE_CLKS    - debouncer stable-sample requirement, clocks
//     last_cnt()        - converts a phase length into its terminal count
// -----------------------------------------------------------------------------
package otter_io_pkg;

    typedef enum logic [1:0] {
        ST_idle = 2'd0,
        ST_high = 2'd1,
        ST_low  = 2'd2
    } stretch_state_e;

    localparam int CNT_W          = 8;
    localparam int DEF_HIGH_CLKS  = 25;
    localparam int DEF_LOW_CLKS   = 50;
    localparam int DEF_PEND_W     = 4;
    localparam int DB_STABLE_CLKS = 250_000;

    // A phase of N clocks ends when the counter (which starts at 0 on
    // state entry) reaches N-1.
    function automatic logic [CNT_W-1:0] last_cnt(input int clks);
        return CNT_W'(clks - 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Up/down counter that saturates at both ends. Simultaneous inc and dec
//   leave the count unchanged. Used to hold the number of queued events in
//   the pulse stretcher.
//
//   Parameters:
//     W      - counter width; range 0 .. 2**W-1
//   Ports:
//     clk    in   clock, posedge
//     rst    in   synchronous active-high reset (count -> 0)
//     inc    in   add one (ignored when full, unless dec also set)
//     dec    in   subtract one (ignored when empty, unless inc also set)
//     count  out  current count (registered)
//     full   out  count == 2**W-1
//     empty  out  count == 0
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         full,
    output logic         empty
);

    localparam logic [W-1:0] MAX_COUNT = '1;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && !dec && (count_q != MAX_COUNT)) begin
            count_d = count_q + W'(1);
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign full  = (count_q == MAX_COUNT);
    assign empty = (count_q == '0);

endmodule

// File: rtl/pulse_stretch_out.sv
// -----------------------------------------------------------------------------
// pulse_stretch_out
//   Turns single-cycle event strobes into human-visible pulses on a board
//   pin. Each event gives HIGH_CLKS clocks high followed by LOW_CLKS clocks
//   low. Strobes arriving while a pulse/guard is in progress are queued in
//   a saturating counter; strobes arriving with the queue full are dropped
//   and flagged on the sticky OVERFLOW bit.
//
//   Parameters:
//     HIGH_CLKS  pulse high time, clocks (1..255)
//     LOW_CLKS   guard low time after every pulse, clocks (1..255)
//     PEND_W     pending counter width; up to 2**PEND_W-1 queued events
//   Ports:
//     CLK        in   clock, all logic on posedge
//     RST        in   synchronous active-high reset
//     STROBE     in   one event per cycle it is high
//     CLR_OVF    in   clears OVERFLOW (a new drop in the same cycle wins)
//     OUT_PIN    out  stretched pulse, straight from a flop
//     BUSY       out  state != ST_idle (registered)
//     PENDING    out  queued events not yet started
//     OVERFLOW   out  sticky, set when a strobe is dropped
//     DBG_STATE  out  current FSM state, for observation only
//
//   Handshake: STROBE has no back-pressure. Every cycle STROBE is high is one
//   event; it is either started directly, queued, or dropped (OVERFLOW).
// -----------------------------------------------------------------------------
module pulse_stretch_out
    import otter_io_pkg::*;
#(
    parameter int HIGH_CLKS = DEF_HIGH_CLKS,
    parameter int LOW_CLKS  = DEF_LOW_CLKS,
    parameter int PEND_W    = DEF_PEND_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              STROBE,
    input  logic              CLR_OVF,
    output logic              OUT_PIN,
    output logic              BUSY,
    output logic [PEND_W-1:0] PENDING,
    output logic              OVERFLOW,
    output stretch_state_e    DBG_STATE
);

    localparam logic [CNT_W-1:0] HIGH_LAST = last_cnt(HIGH_CLKS);
    localparam logic [CNT_W-1:0] LOW_LAST  = last_cnt(LOW_CLKS);

    stretch_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;

    logic [PEND_W-1:0] pend_count;
    logic              pend_full;
    logic              pend_empty;

    logic high_done;
    logic low_done;
    logic start_pend;
    logic direct;
    logic accept;
    logic drop;

    assign high_done = (state_q == ST_high) && (cnt_q == HIGH_LAST);
    assign low_done  = (state_q == ST_low)  && (cnt_q == LOW_LAST);

    // A queued event is launched at the end of a guard period.
    assign start_pend = low_done && !pend_empty;

    // A strobe bypasses the queue only when it is itself what launches the
    // next pulse: from idle, or at the end of a guard with nothing queued.
    assign direct = STROBE && ((state_q == ST_idle) || (low_done && pend_empty));
    assign accept = STROBE && !direct;

    // A simultaneous launch frees a slot, so a full queue only drops when
    // nothing is leaving it this cycle.
    assign drop = accept && pend_full && !start_pend;

    sat_counter #(
        .W (PEND_W)
    ) u_pend (
        .clk   (CLK),
        .rst   (RST),
        .inc   (accept),
        .dec   (start_pend),
        .count (pend_count),
        .full  (pend_full),
        .empty (pend_empty)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        out_d   = out_q;

        case (state_q)
            ST_idle: begin
                cnt_d = '0;
                out_d = 1'b0;
                if (STROBE) begin
                    state_d = ST_high;
                    out_d   = 1'b1;
                end
            end
            ST_high: begin
                out_d = 1'b1;
                if (high_done) begin
                    state_d = ST_low;
                    cnt_d   = '0;
                    out_d   = 1'b0;
                end
            end
            ST_low: begin
                out_d = 1'b0;
                if (low_done) begin
                    cnt_d = '0;
                    if (!pend_empty || STROBE) begin
                        state_d = ST_high;
                        out_d   = 1'b1;
                    end else begin
                        state_d = ST_idle;
                    end
                end
            end
            default: begin
                state_d = ST_idle;
                cnt_d   = '0;
                out_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_idle);

        if (drop) begin
            ovf_d = 1'b1;
        end else if (CLR_OVF) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_idle;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign OUT_PIN   = out_q;
    assign BUSY      = busy_q;
    assign PENDING   = pend_count;
    assign OVERFLOW  = ovf_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_pulse_stretch_out.sv
// -----------------------------------------------------------------------------
// tb_pulse_stretch_out
//   Two instances: dut_a with default timing (25 high / 50 low, 4-bit queue)
//   and dut_b with 1/1 timing and a 2-bit queue. Edge numbers count rising
//   clock edges; outputs are sampled on the falling edge, where cyc holds the
//   number of the edge just taken. Each expected pulse is queued as
//   {rise_edge, high_width}; a monitor per DUT pops and compares on every
//   falling edge of OUT_PIN.
// -----------------------------------------------------------------------------
module tb_pulse_stretch_out;
    import otter_io_pkg::*;

    localparam int HA = 25;
    localparam int LA = 50;
    localparam int PA = HA + LA;

    logic clk;
    int   cyc;

    // dut_a signals
    logic           rst_a, strobe_a, clr_a;
    logic           out_a, busy_a, ovf_a;
    logic [3:0]     pend_a;
    stretch_state_e st_a;

    // dut_b signals
    logic           rst_b, strobe_b, clr_b;
    logic           out_b, busy_b, ovf_b;
    logic [1:0]     pend_b;
    stretch_state_e st_b;

    // scoreboard
    logic [47:0] exp_q_a[$];
    logic [47:0] exp_q_b[$];
    int n_vec;
    int n_err;

    // monitor state
    logic prev_a, prev_b;
    int   rise_a, rise_b;

    pulse_stretch_out #(
        .HIGH_CLKS (HA),
        .LOW_CLKS  (LA),
        .PEND_W    (4)
    ) dut_a (
        .CLK       (clk),
        .RST       (rst_a),
        .STROBE    (strobe_a),
        .CLR_OVF   (clr_a),
        .OUT_PIN   (out_a),
        .BUSY      (busy_a),
        .PENDING   (pend_a),
        .OVERFLOW  (ovf_a),
        .DBG_STATE (st_a)
    );

    pulse_stretch_out #(
        .HIGH_CLKS (1),
        .LOW_CLKS  (1),
        .PEND_W    (2)
    ) dut_b (
        .CLK       (clk),
        .RST       (rst_b),
        .STROBE    (strobe_b),
        .CLR_OVF   (clr_b),
        .OUT_PIN   (out_b),
        .BUSY      (busy_b),
        .PENDING   (pend_b),
        .OVERFLOW  (ovf_b),
        .DBG_STATE (st_b)
    );

    // ---------------- clock / edge counter ----------------
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard monitors ----------------
    initial begin
        prev_a = 1'b0;
        prev_b = 1'b0;
        rise_a = 0;
        rise_b = 0;
    end

    always @(negedge clk) begin
        logic [47:0] got;
        logic [47:0] e;
        if (out_a === 1'b1 && prev_a === 1'b0) rise_a = cyc;
        if (out_a === 1'b0 && prev_a === 1'b1) begin
            got = {32'(rise_a), 16'(cyc - rise_a)};
            n_vec++;
            if (exp_q_a.size() == 0) begin
                n_err++;
                $display("FAIL pulse_a: unexpected pulse rise=%0d width=%0d", rise_a, cyc - rise_a);
            end else begin
                e = exp_q_a.pop_front();
                if (e !== got) begin
                    n_err++;
                    $display("FAIL pulse_a: got rise=%0d width=%0d, expected rise=%0d width=%0d",
                             got[47:16], got[15:0], e[47:16], e[15:0]);
                end
            end
        end
        prev_a = out_a;
    end

    always @(negedge clk) begin
        logic [47:0] got;
        logic [47:0] e;
        if (out_b === 1'b1 && prev_b === 1'b0) rise_b = cyc;
        if (out_b === 1'b0 && prev_b === 1'b1) begin
            got = {32'(rise_b), 16'(cyc - rise_b)};
            n_vec++;
            if (exp_q_b.size() == 0) begin
                n_err++;
                $display("FAIL pulse_b: unexpected pulse rise=%0d width=%0d", rise_b, cyc - rise_b);
            end else begin
                e = exp_q_b.pop_front();
                if (e !== got) begin
                    n_err++;
                    $display("FAIL pulse_b: got rise=%0d width=%0d, expected rise=%0d width=%0d",
                             got[47:16], got[15:0], e[47:16], e[15:0]);
                end
            end
        end
        prev_b = out_b;
    end

    // ---------------- driver / check tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Advance to the falling edge after rising edge e.
    task automatic go_to(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    // One-cycle strobe on dut_a; k is the rising edge that samples it.
    task automatic strobe_one_a(output int k);
        k = cyc + 1;
        strobe_a = 1'b1;
        @(negedge clk);
        strobe_a = 1'b0;
    endtask

    task automatic expect_a(input int rise, input int width);
        exp_q_a.push_back({32'(rise), 16'(width)});
    endtask

    task automatic expect_b(input int rise, input int width);
        exp_q_b.push_back({32'(rise), 16'(width)});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k0, k1, k2, k3;
        n_vec = 0;
        n_err = 0;
        rst_a = 1'b1; strobe_a = 1'b0; clr_a = 1'b0;
        rst_b = 1'b1; strobe_b = 1'b0; clr_b = 1'b0;

        // Reset state, with STROBE high during reset (must be ignored).
        step();
        strobe_a = 1'b1;
        step(); step();
        check("rst_out",  32'(out_a),  0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_pend", 32'(pend_a), 0);
        check("rst_ovf",  32'(ovf_a),  0);
        check("rst_state", 32'(st_a),  32'(ST_idle));
        strobe_a = 1'b0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        step(); step();
        check("rst_strobe_ignored", 32'(busy_a), 0);

        // --- dut_b: 1/1 timing, continuous strobe over 10 edges ---
        k0 = cyc + 1;
        strobe_b = 1'b1;
        for (int i = 0; i < 8; i++) expect_b(k0 + 2 * i, 1);
        go_to(k0 + 1);
        check("b_pend_first", 32'(pend_b), 1);
        go_to(k0 + 6);
        check("b_pend_full", 32'(pend_b), 3);
        check("b_ovf_before", 32'(ovf_b), 0);
        go_to(k0 + 7);
        check("b_ovf_drop", 32'(ovf_b), 1);
        go_to(k0 + 9);
        strobe_b = 1'b0;
        check("b_pend_end", 32'(pend_b), 3);
        go_to(k0 + 14);
        check("b_pend_drained", 32'(pend_b), 0);
        go_to(k0 + 15);
        check("b_busy_guard", 32'(busy_b), 1);
        go_to(k0 + 16);
        check("b_busy_done", 32'(busy_b), 0);
        clr_b = 1'b1;
        step();
        clr_b = 1'b0;
        check("b_ovf_clr", 32'(ovf_b), 0);

        // --- T1: single strobe ---
        strobe_one_a(k0);
        expect_a(k0, HA);
        check("t1_out_rise", 32'(out_a), 1);
        check("t1_pend", 32'(pend_a), 0);
        go_to(k0 + HA - 1);
        check("t1_out_last_high", 32'(out_a), 1);
        go_to(k0 + HA);
        check("t1_out_fall", 32'(out_a), 0);
        go_to(k0 + PA - 1);
        check("t1_busy_guard", 32'(busy_a), 1);
        go_to(k0 + PA);
        check("t1_busy_done", 32'(busy_a), 0);
        check("t1_pend_end", 32'(pend_a), 0);

        // --- T2: three strobes two edges apart ---
        step();
        strobe_one_a(k0);
        step();
        strobe_one_a(k1);
        check("t2_pend1", 32'(pend_a), 1);
        step();
        strobe_one_a(k2);
        check("t2_pend2", 32'(pend_a), 2);
        expect_a(k0, HA);
        expect_a(k0 + PA, HA);
        expect_a(k0 + 2 * PA, HA);
        go_to(k0 + PA);
        check("t2_pend_after_start1", 32'(pend_a), 1);
        go_to(k0 + 2 * PA);
        check("t2_pend_after_start2", 32'(pend_a), 0);
        go_to(k0 + 3 * PA - 1);
        check("t2_busy_guard", 32'(busy_a), 1);
        go_to(k0 + 3 * PA);
        check("t2_busy_done", 32'(busy_a), 0);

        // --- T3: strobe held for 20 edges -> saturation and overflow ---
        step();
        k0 = cyc + 1;
        strobe_a = 1'b1;
        for (int i = 0; i < 16; i++) expect_a(k0 + PA * i, HA);
        go_to(k0 + 15);
        check("t3_pend_sat", 32'(pend_a), 15);
        check("t3_ovf_not_yet", 32'(ovf_a), 0);
        go_to(k0 + 16);
        check("t3_ovf_set", 32'(ovf_a), 1);
        check("t3_pend_hold", 32'(pend_a), 15);
        go_to(k0 + 18);
        clr_a = 1'b1;               // same edge as a drop: set wins
        step();
        strobe_a = 1'b0;
        clr_a = 1'b0;
        check("t3_ovf_set_beats_clr", 32'(ovf_a), 1);
        check("t3_pend_end", 32'(pend_a), 15);
        go_to(k0 + 16 * PA - 1);
        check("t3_busy_guard", 32'(busy_a), 1);
        go_to(k0 + 16 * PA);
        check("t3_busy_done", 32'(busy_a), 0);
        check("t3_pend_drained", 32'(pend_a), 0);
        check("t3_ovf_sticky", 32'(ovf_a), 1);
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        check("t3_ovf_clr", 32'(ovf_a), 0);

        // --- T4a: strobe in final guard cycle, nothing queued ---
        step();
        strobe_one_a(k0);
        expect_a(k0, HA);
        expect_a(k0 + PA, HA);
        go_to(k0 + PA - 1);
        check("t4a_out_low", 32'(out_a), 0);
        strobe_a = 1'b1;
        step();
        strobe_a = 1'b0;
        check("t4a_out_restart", 32'(out_a), 1);
        check("t4a_busy", 32'(busy_a), 1);
        check("t4a_pend", 32'(pend_a), 0);
        go_to(k0 + 2 * PA);
        check("t4a_busy_done", 32'(busy_a), 0);

        // --- T4b: strobe in final guard cycle with two queued ---
        step();
        strobe_one_a(k0);
        step();
        strobe_one_a(k1);
        step();
        strobe_one_a(k2);
        check("t4b_pend2", 32'(pend_a), 2);
        for (int i = 0; i < 4; i++) expect_a(k0 + PA * i, HA);
        go_to(k0 + PA - 1);
        strobe_a = 1'b1;
        step();
        strobe_a = 1'b0;
        check("t4b_pend_unchanged", 32'(pend_a), 2);
        go_to(k0 + 4 * PA);
        check("t4b_busy_done", 32'(busy_a), 0);
        check("t4b_pend_end", 32'(pend_a), 0);

        // --- T5: reset mid-pulse with three queued ---
        step();
        strobe_one_a(k0);
        step();
        strobe_one_a(k1);
        step();
        strobe_one_a(k2);
        step();
        strobe_one_a(k3);
        check("t5_pend3", 32'(pend_a), 3);
        expect_a(k0, 10);
        go_to(k0 + 9);
        rst_a = 1'b1;
        strobe_a = 1'b1;
        step();
        rst_a = 1'b0;
        strobe_a = 1'b0;
        check("t5_out", 32'(out_a), 0);
        check("t5_busy", 32'(busy_a), 0);
        check("t5_pend", 32'(pend_a), 0);
        go_to(k0 + 4 * PA);
        check("t5_no_more_busy", 32'(busy_a), 0);
        check("t5_no_more_out", 32'(out_a), 0);

        // Every queued pulse must have been seen.
        step(); step();
        check("sb_a_empty", 32'(exp_q_a.size()), 0);
        check("sb_b_empty", 32'(exp_q_b.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
